// File: rtl/vdcorput_inverse.sv
// Van der Corput inverse: recovers the sequence index by base-BASE digit reversal over SCALE digits.
// Optional range flag for inputs >= BASE**SCALE is built when VDC_INV_RANGE_CHECK_EN is defined.
module vdcorput_inverse #(
  parameter int unsigned BASE  = 2,
  parameter int unsigned SCALE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] vdc_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] k_out,
  output logic        err
);

  // Saturates just past 2**32 so absurd SCALE values cannot wrap into a legal-looking limit.
  function automatic longint unsigned pow_sat(input int unsigned b, input int unsigned e);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < e; i++) begin
      if (r < 64'h1_0000_0000) r = r * longint'(b);
    end
    return r;
  endfunction

  localparam longint unsigned Limit = pow_sat(BASE, SCALE);
  localparam int unsigned CntW = $clog2(SCALE + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(SCALE - 1);

  if (!(BASE == 2 || BASE == 3 || BASE == 7) || SCALE < 1 || Limit >= 64'h1_0000_0000)
  begin : g_bad_param
    $error("vdcorput_inverse: illegal BASE/SCALE combination");
  end

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e          state_q, state_d;
  logic [31:0]     x_q, x_d;
  logic [31:0]     k_q, k_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          x_d     = vdc_in;
          k_d     = '0;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        // Always runs the full SCALE digits so latency is data-independent.
        x_d   = x_q / BASE;
        k_d   = k_q * BASE + x_q % BASE;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) state_d = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef VDC_INV_RANGE_CHECK_EN
  localparam logic [31:0] Limit32 = Limit[31:0];

  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state_q == StIdle && in_valid) begin
      err_q <= (vdc_in >= Limit32);
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign k_out = err ? '0 : k_q;

endmodule
